// File: rtl/raw_bin2x2_luma.sv
// raw_bin2x2_luma: 2x2 Bayer binning of a RAW mosaic stream into a
// half-resolution gray/luma stream.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   sink_*              RAW pixel input (raster order), ready/valid
//   source_*            binned gray output, ready/valid, sof/eol qualifiers
//   control_in_*        geometry packet {width[35:20], height[19:4], 4'bx}
//   control_out_*       output geometry packet {width>>1, height>>1, 4'h0}
//   mode                0 = plain 4-pixel average, 1 = BT.601 weighted luma
//   bayer_pat           0=RGGB 1=GRBG 2=GBRG 3=BGGR
// mode and bayer_pat are captured with the first beat of each frame.
`timescale 1ns/1ps
module raw_bin2x2_luma #(
  parameter int BITWIDTH = 8,
  parameter int MAX_W    = 1920,
  parameter int DEF_W    = 1920,
  parameter int DEF_H    = 1080
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BITWIDTH-1:0] sink_data,
  input  logic                sink_valid,
  output logic                sink_ready,
  output logic [BITWIDTH-1:0] source_data,
  output logic                source_valid,
  input  logic                source_ready,
  output logic                source_sof,
  output logic                source_eol,
  input  logic [35:0]         control_in_data,
  input  logic                control_in_valid,
  output logic [35:0]         control_out_data,
  output logic                control_out_valid,
  input  logic                mode,
  input  logic [1:0]          bayer_pat
);

  localparam int DEPTH = (MAX_W / 2 > 1) ? MAX_W / 2 : 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = BITWIDTH;
  localparam int PW    = 2 * BITWIDTH;
  localparam int AVG_W = BITWIDTH + 2;
  localparam int LUM_W = BITWIDTH + 8;
  localparam logic [15:0] MAX_W16 = 16'(MAX_W);
  localparam logic [15:0] DEF_W16 = (DEF_W > MAX_W) ? 16'(MAX_W) : 16'(DEF_W);
  localparam logic [15:0] DEF_H16 = 16'(DEF_H);

  function automatic logic [BITWIDTH-1:0] round_avg(input logic [AVG_W-1:0] s);
    logic [AVG_W-1:0] t;
    t = s + AVG_W'(2);
    return t[AVG_W-1:2];
  endfunction

  // Weights sum to 256, so the rounded result always fits BITWIDTH bits.
  function automatic logic [BITWIDTH-1:0] round_luma(input logic [LUM_W-1:0] s);
    logic [LUM_W-1:0] t;
    t = s + LUM_W'(128);
    return t[LUM_W-1:8];
  endfunction

  // ---------------- control state ----------------
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [15:0] act_w_q, act_w_d, act_h_q, act_h_d;
  logic [15:0] pend_w_q, pend_w_d, pend_h_q, pend_h_d;
  logic        pend_vld_q, pend_vld_d;
  logic        mode_q, mode_d;
  logic [1:0]  pat_q, pat_d;
  logic        boot_q, boot_d;
  logic        ctl_vld_q, ctl_vld_d;
  logic [35:0] ctl_data_q, ctl_data_d;

  logic        fs, en, acc, x_last, y_last, cur_mode;
  logic [1:0]  cur_pat;
  logic [15:0] cur_w, cur_h, ci_w, ci_h;

  assign en         = !source_valid || source_ready;
  assign sink_ready = en;
  assign acc        = sink_valid && en;
  // x,y both zero only before the first beat of a frame is taken.
  assign fs         = (x_q == 16'd0) && (y_q == 16'd0);
  assign ci_w       = (control_in_data[35:20] > MAX_W16) ? MAX_W16 : control_in_data[35:20];
  assign ci_h       = control_in_data[19:4];

  always_comb begin
    cur_w    = act_w_q;
    cur_h    = act_h_q;
    cur_mode = mode_q;
    cur_pat  = pat_q;
    if (fs) begin
      cur_mode = mode;
      cur_pat  = bayer_pat;
      // A packet arriving together with the frame-start beat takes effect now.
      if (control_in_valid) begin
        cur_w = ci_w;
        cur_h = ci_h;
      end else if (pend_vld_q) begin
        cur_w = pend_w_q;
        cur_h = pend_h_q;
      end
    end
  end

  assign x_last = ({1'b0, x_q} + 17'd1) >= {1'b0, cur_w};
  assign y_last = ({1'b0, y_q} + 17'd1) >= {1'b0, cur_h};

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    act_w_d    = act_w_q;
    act_h_d    = act_h_q;
    pend_w_d   = pend_w_q;
    pend_h_d   = pend_h_q;
    pend_vld_d = pend_vld_q;
    mode_d     = mode_q;
    pat_d      = pat_q;
    boot_d     = 1'b1;
    ctl_vld_d  = control_in_valid || !boot_q;
    ctl_data_d = ctl_data_q;

    if (fs) begin
      act_w_d    = cur_w;
      act_h_d    = cur_h;
      pend_vld_d = 1'b0;
    end else if (control_in_valid) begin
      pend_vld_d = 1'b1;
      pend_w_d   = ci_w;
      pend_h_d   = ci_h;
    end

    if (acc) begin
      if (fs) begin
        mode_d = mode;
        pat_d  = bayer_pat;
      end
      if (x_last) begin
        x_d = 16'd0;
        y_d = y_last ? 16'd0 : y_q + 16'd1;
      end else begin
        x_d = x_q + 16'd1;
      end
    end

    if (control_in_valid)
      ctl_data_d = {ci_w >> 1, ci_h >> 1, 4'h0};
    else if (!boot_q)
      ctl_data_d = {DEF_W16 >> 1, DEF_H16 >> 1, 4'h0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q        <= 16'd0;
      y_q        <= 16'd0;
      act_w_q    <= DEF_W16;
      act_h_q    <= DEF_H16;
      pend_w_q   <= DEF_W16;
      pend_h_q   <= DEF_H16;
      pend_vld_q <= 1'b0;
      mode_q     <= 1'b0;
      pat_q      <= 2'd0;
      boot_q     <= 1'b0;
      ctl_vld_q  <= 1'b0;
      ctl_data_q <= 36'd0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      act_w_q    <= act_w_d;
      act_h_q    <= act_h_d;
      pend_w_q   <= pend_w_d;
      pend_h_q   <= pend_h_d;
      pend_vld_q <= pend_vld_d;
      mode_q     <= mode_d;
      pat_q      <= pat_d;
      boot_q     <= boot_d;
      ctl_vld_q  <= ctl_vld_d;
      ctl_data_q <= ctl_data_d;
    end
  end

  assign control_out_valid = ctl_vld_q;
  assign control_out_data  = ctl_data_q;

  // ---------------- line buffer ----------------
  // Even rows store each pixel pair; the matching odd-row pair reads it back
  // on its first (even-x) pixel so the registered read is ready for P11.
  logic [PW-1:0] lb_mem [DEPTH];
  logic [PW-1:0] lb_rd_q;
  logic [AW-1:0] lb_addr;
  logic          lb_wr, lb_rd;
  logic [BW-1:0] left_q, left_d;

  assign lb_addr = x_q[AW:1];
  assign lb_wr   = acc && x_q[0] && !y_q[0];
  assign lb_rd   = acc && !x_q[0];
  assign left_d  = lb_rd ? sink_data : left_q;

  always_ff @(posedge clk) begin
    if (lb_wr) lb_mem[lb_addr] <= {left_q, sink_data};
    if (lb_rd) lb_rd_q <= lb_mem[lb_addr];
    left_q <= left_d;
  end

  // ---------------- stage p0: block capture ----------------
  logic            vld_p0_q, vld_p0_d, sof_p0_q, sof_p0_d, eol_p0_q, eol_p0_d;
  logic            mode_p0_q, mode_p0_d;
  logic [1:0]      pat_p0_q, pat_p0_d;
  logic [4*BW-1:0] pix_p0_q, pix_p0_d;

  always_comb begin
    vld_p0_d  = vld_p0_q;
    sof_p0_d  = sof_p0_q;
    eol_p0_d  = eol_p0_q;
    mode_p0_d = mode_p0_q;
    pat_p0_d  = pat_p0_q;
    pix_p0_d  = pix_p0_q;
    if (en) begin
      vld_p0_d  = acc && x_q[0] && y_q[0];
      sof_p0_d  = (x_q == 16'd1) && (y_q == 16'd1);
      eol_p0_d  = (x_q >> 1) == ((cur_w >> 1) - 16'd1);
      mode_p0_d = cur_mode;
      pat_p0_d  = cur_pat;
      pix_p0_d  = {lb_rd_q, left_q, sink_data};
    end
  end

  // ---------------- stage p1: channel map, weights ----------------
  logic             vld_p1_q, vld_p1_d, sof_p1_q, sof_p1_d, eol_p1_q, eol_p1_d;
  logic             mode_p1_q, mode_p1_d;
  logic [AVG_W-1:0] sum_p1_q, sum_p1_d;
  logic [LUM_W-1:0] wr_p1_q, wr_p1_d, wg_p1_q, wg_p1_d, wb_p1_q, wb_p1_d;
  logic [BW-1:0]    p00, p01, p10, p11, ch_r, ch_g1, ch_g2, ch_b;

  assign p00 = pix_p0_q[4*BW-1 -: BW];
  assign p01 = pix_p0_q[3*BW-1 -: BW];
  assign p10 = pix_p0_q[2*BW-1 -: BW];
  assign p11 = pix_p0_q[BW-1:0];

  always_comb begin
    case (pat_p0_q)
      2'd0:    begin ch_r = p00; ch_b = p11; ch_g1 = p01; ch_g2 = p10; end
      2'd1:    begin ch_r = p01; ch_b = p10; ch_g1 = p00; ch_g2 = p11; end
      2'd2:    begin ch_r = p10; ch_b = p01; ch_g1 = p00; ch_g2 = p11; end
      default: begin ch_r = p11; ch_b = p00; ch_g1 = p01; ch_g2 = p10; end
    endcase
  end

  always_comb begin
    vld_p1_d  = vld_p1_q;
    sof_p1_d  = sof_p1_q;
    eol_p1_d  = eol_p1_q;
    mode_p1_d = mode_p1_q;
    sum_p1_d  = sum_p1_q;
    wr_p1_d   = wr_p1_q;
    wg_p1_d   = wg_p1_q;
    wb_p1_d   = wb_p1_q;
    if (en) begin
      vld_p1_d  = vld_p0_q;
      sof_p1_d  = sof_p0_q;
      eol_p1_d  = eol_p0_q;
      mode_p1_d = mode_p0_q;
      sum_p1_d  = AVG_W'(p00) + AVG_W'(p01) + AVG_W'(p10) + AVG_W'(p11);
      wr_p1_d   = LUM_W'(ch_r) * LUM_W'(77);
      wg_p1_d   = (LUM_W'(ch_g1) + LUM_W'(ch_g2)) * LUM_W'(75);
      wb_p1_d   = LUM_W'(ch_b) * LUM_W'(29);
    end
  end

  // ---------------- stage p2: round and output ----------------
  logic          src_vld_q, src_vld_d, src_sof_q, src_sof_d, src_eol_q, src_eol_d;
  logic [BW-1:0] src_data_q, src_data_d;

  always_comb begin
    src_vld_d  = src_vld_q;
    src_sof_d  = src_sof_q;
    src_eol_d  = src_eol_q;
    src_data_d = src_data_q;
    if (en) begin
      src_vld_d  = vld_p1_q;
      src_sof_d  = sof_p1_q;
      src_eol_d  = eol_p1_q;
      src_data_d = mode_p1_q ? round_luma(wr_p1_q + wg_p1_q + wb_p1_q) : round_avg(sum_p1_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      src_vld_q  <= 1'b0;
      src_sof_q  <= 1'b0;
      src_eol_q  <= 1'b0;
      src_data_q <= '0;
    end else begin
      vld_p0_q   <= vld_p0_d;
      vld_p1_q   <= vld_p1_d;
      src_vld_q  <= src_vld_d;
      src_sof_q  <= src_sof_d;
      src_eol_q  <= src_eol_d;
      src_data_q <= src_data_d;
    end
  end

  always_ff @(posedge clk) begin
    sof_p0_q  <= sof_p0_d;
    eol_p0_q  <= eol_p0_d;
    mode_p0_q <= mode_p0_d;
    pat_p0_q  <= pat_p0_d;
    pix_p0_q  <= pix_p0_d;
    sof_p1_q  <= sof_p1_d;
    eol_p1_q  <= eol_p1_d;
    mode_p1_q <= mode_p1_d;
    sum_p1_q  <= sum_p1_d;
    wr_p1_q   <= wr_p1_d;
    wg_p1_q   <= wg_p1_d;
    wb_p1_q   <= wb_p1_d;
  end

  assign source_valid = src_vld_q;
  assign source_data  = src_data_q;
  assign source_sof   = src_sof_q;
  assign source_eol   = src_eol_q;

endmodule

// File: tb/tb_raw_bin2x2_luma.sv
`timescale 1ns/1ps
module tb_raw_bin2x2_luma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sink_data;
  logic        sink_valid;
  logic        sink_ready;
  logic [7:0]  source_data;
  logic        source_valid;
  logic        source_ready;
  logic        source_sof;
  logic        source_eol;
  logic [35:0] control_in_data;
  logic        control_in_valid;
  logic [35:0] control_out_data;
  logic        control_out_valid;
  logic        mode;
  logic [1:0]  bayer_pat;

  always #5 clk = ~clk;

  raw_bin2x2_luma #(.BITWIDTH(8), .MAX_W(1920), .DEF_W(1920), .DEF_H(1080)) dut (
    .clk(clk), .rst(rst),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
    .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
    .source_sof(source_sof), .source_eol(source_eol),
    .control_in_data(control_in_data), .control_in_valid(control_in_valid),
    .control_out_data(control_out_data), .control_out_valid(control_out_valid),
    .mode(mode), .bayer_pat(bayer_pat)
  );

  typedef struct packed { logic [7:0] d; logic sof; logic eol; } exp_t;
  exp_t sb[$];
  exp_t e_out;

  int n_checks = 0;
  int n_errors = 0;
  int n_out = 0;
  int n_acc = 0;
  int n_pulse = 0;
  logic [35:0] last_cod = '0;
  logic rnd_rdy = 1'b0;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int kind, input int x, input int y);
    if (kind == 0) begin
      case ({y[0], x[0]})
        2'b00: return 10;
        2'b01: return 20;
        2'b10: return 30;
        default: return 41;
      endcase
    end
    if (kind == 1) return (x + y) & 255;
    return 255;
  endfunction

  function automatic logic [7:0] model(input int p00, input int p01, input int p10, input int p11,
                                       input logic md, input logic [1:0] pat);
    int r, g1, g2, b;
    if (!md) return 8'((p00 + p01 + p10 + p11 + 2) / 4);
    case (pat)
      2'd0:    begin r = p00; b = p11; g1 = p01; g2 = p10; end
      2'd1:    begin r = p01; b = p10; g1 = p00; g2 = p11; end
      2'd2:    begin r = p10; b = p01; g1 = p00; g2 = p11; end
      default: begin r = p11; b = p00; g1 = p01; g2 = p10; end
    endcase
    return 8'((77 * r + 75 * g1 + 75 * g2 + 29 * b + 128) / 256);
  endfunction

  // Output monitor / scoreboard consumer, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (control_out_valid) begin
        n_pulse++;
        last_cod = control_out_data;
      end
      if (sink_valid && sink_ready) n_acc++;
      if (source_valid && !source_ready) chk("stall_sink_ready", 40'(sink_ready), 40'd0);
      if (source_valid && source_ready) begin
        n_out++;
        n_checks++;
        assert (sb.size() > 0) else begin
          n_errors++;
          $error("FAIL unexpected_out observed=%0h expected=none", source_data);
        end
        if (sb.size() > 0) begin
          e_out = sb.pop_front();
          chk("out_data", 40'(source_data), 40'(e_out.d));
          chk("out_sof", 40'(source_sof), 40'(e_out.sof));
          chk("out_eol", 40'(source_eol), 40'(e_out.eol));
        end
      end
    end
  end

  initial begin
    source_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      source_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input int d, input int gap);
    logic acc_now;
    logic ok;
    repeat (gap) begin sink_valid = 1'b0; @(posedge clk); #1; end
    sink_valid = 1'b1;
    sink_data  = 8'(d);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      acc_now = sink_ready;
      @(posedge clk); #1;
      if (acc_now) begin ok = 1'b1; break; end
    end
    sink_valid = 1'b0;
    if (!ok) chk("beat_accept", 40'(ok), 40'd1);
  endtask

  task automatic send_ctl(input int w, input int h);
    control_in_data  = {16'(w), 16'(h), 4'h5};
    control_in_valid = 1'b1;
    @(posedge clk); #1;
    control_in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Drives n_max beats (-1 = whole frame); pushes an expectation on every P11.
  task automatic send_frame(input int w, input int h, input int kind, input logic md,
                            input logic [1:0] pat, input logic rnd, input int inj_at,
                            input logic [35:0] inj, input int n_max);
    exp_t e;
    int idx;
    mode = md;
    bayer_pat = pat;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        idx = y * w + x;
        if (n_max >= 0 && idx >= n_max) return;
        if (idx == inj_at) begin
          control_in_data  = inj;
          control_in_valid = 1'b1;
          mode = !md;
          bayer_pat = pat + 2'd1;
          @(posedge clk); #1;
          control_in_valid = 1'b0;
        end
        if ((x % 2 == 1) && (y % 2 == 1)) begin
          e.d   = model(pix(kind, x - 1, y - 1), pix(kind, x, y - 1),
                        pix(kind, x - 1, y), pix(kind, x, y), md, pat);
          e.sof = (x == 1) && (y == 1);
          e.eol = (x / 2) == (w / 2 - 1);
          sb.push_back(e);
        end
        send_beat(pix(kind, x, y), rnd ? int'($urandom_range(0, 2)) : 0);
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int t = 0; t < 3000; t++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    repeat (6) begin @(posedge clk); #1; end
    chk(tag, 40'(sb.size()), 40'd0);
  endtask

  int o0, p0, a0;

  initial begin
    sink_valid = 1'b0; sink_data = '0;
    control_in_valid = 1'b0; control_in_data = '0;
    mode = 1'b0; bayer_pat = 2'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_source_valid", 40'(source_valid), 40'd0);
    chk("rst_source_data", 40'(source_data), 40'd0);
    chk("rst_sof_eol", 40'({source_sof, source_eol}), 40'd0);
    chk("rst_ctl_valid", 40'(control_out_valid), 40'd0);
    chk("rst_ctl_data", 40'(control_out_data), 40'd0);
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("boot_pulse", 40'(n_pulse), 40'd1);
    chk("boot_ctl_data", 40'(last_cod), 40'({16'd960, 16'd540, 4'h0}));

    // 4x4, average, then weighted RGGB and BGGR
    send_ctl(4, 4);
    chk("ctl_pulse_4x4", 40'(n_pulse), 40'd2);
    chk("ctl_data_4x4", 40'(last_cod), 40'({16'd2, 16'd2, 4'h0}));
    o0 = n_out;
    send_frame(4, 4, 0, 1'b0, 2'd0, 1'b0, -1, '0, -1);
    wait_drain("drain_avg");
    chk("count_avg", 40'(n_out - o0), 40'd4);
    o0 = n_out;
    send_frame(4, 4, 0, 1'b1, 2'd0, 1'b0, -1, '0, -1);
    wait_drain("drain_rggb");
    chk("count_rggb", 40'(n_out - o0), 40'd4);
    send_frame(4, 4, 0, 1'b1, 2'd3, 1'b0, -1, '0, -1);
    wait_drain("drain_bggr");

    // 64x8 with random gaps and random backpressure
    send_ctl(64, 8);
    rnd_rdy = 1'b1;
    o0 = n_out;
    send_frame(64, 8, 1, 1'b1, 2'd1, 1'b1, -1, '0, -1);
    wait_drain("drain_random");
    rnd_rdy = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("count_random", 40'(n_out - o0), 40'd128);

    // control packet mid-frame (mode/pattern also toggled mid-frame)
    send_ctl(4, 4);
    p0 = n_pulse;
    o0 = n_out;
    send_frame(4, 4, 0, 1'b0, 2'd0, 1'b0, 5, {16'd6, 16'd4, 4'h0}, -1);
    wait_drain("drain_mid_a");
    chk("count_mid_a", 40'(n_out - o0), 40'd4);
    o0 = n_out;
    send_frame(6, 4, 1, 1'b1, 2'd2, 1'b0, -1, '0, -1);
    wait_drain("drain_mid_b");
    chk("count_mid_b", 40'(n_out - o0), 40'd6);
    chk("mid_pulse_count", 40'(n_pulse - p0), 40'd1);
    chk("mid_ctl_data", 40'(last_cod), 40'({16'd3, 16'd2, 4'h0}));

    // odd geometry
    send_ctl(5, 3);
    a0 = n_acc;
    o0 = n_out;
    send_frame(5, 3, 2, 1'b1, 2'd0, 1'b0, -1, '0, -1);
    wait_drain("drain_odd");
    chk("count_odd", 40'(n_out - o0), 40'd2);
    chk("beats_odd", 40'(n_acc - a0), 40'd15);

    // reset in the middle of row 1
    send_ctl(4, 4);
    send_frame(4, 4, 1, 1'b0, 2'd0, 1'b0, -1, '0, 6);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_source_valid", 40'(source_valid), 40'd0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    p0 = n_pulse;
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_pulse", 40'(n_pulse - p0), 40'd1);
    chk("midrst_ctl_data", 40'(last_cod), 40'({16'd960, 16'd540, 4'h0}));
    send_ctl(4, 4);
    o0 = n_out;
    send_frame(4, 4, 1, 1'b0, 2'd0, 1'b0, -1, '0, -1);
    wait_drain("drain_after_rst");
    chk("count_after_rst", 40'(n_out - o0), 40'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
